led_mux_pwm: RTL and testbench

Row-scanned LED matrix driver with per-pixel PWM brightness. It is the parametrised successor to the on/off row multiplexer.
- Drives one row at a time and modulates each column's on-time within the row period according to a PWM_WIDTH-bit pixel intensity.
- Inserts a blanking interval between rows to suppress ghosting.
- Double-buffers the pixel image at frame start so the display never tears.
- Sits between the frame source (pixel register file or bus) and the matrix row and column drivers.

---
 rtl/led_mux_pwm.sv | 173 +++++++++++++++++
 tb/tb_led_mux_pwm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/led_mux_pwm.sv
// Row-scanned LED matrix driver with per-pixel PWM brightness, inter-row blanking
// and a shadow image that is recaptured only at frame start.
module led_mux_pwm #(
    parameter int NUM_ROWS          = 4,
    parameter int NUM_ROWS_WIDTH    = 2,
    parameter int NUM_COLS          = 8,
    parameter int PWM_WIDTH         = 3,
    parameter int CLOCK_DELAY       = 10,
    parameter int CLOCK_DELAY_WIDTH = 4,
    parameter int BLANK_CYCLES      = 2,
    parameter int BLANK_WIDTH       = 2,
    parameter int ROW_ACTIVE_LOW    = 0,
    parameter int COL_ACTIVE_LOW    = 0
) (
    input  logic                                   clk,
    input  logic                                   i_rst,
    input  logic                                   i_enable,
    input  logic [NUM_ROWS*NUM_COLS*PWM_WIDTH-1:0] i_pixels,
    output logic [NUM_COLS-1:0]                    o_cols,
    output logic [NUM_ROWS-1:0]                    o_rows,
    output logic                                   o_frame_start
);

    localparam int IMG_W = NUM_ROWS * NUM_COLS * PWM_WIDTH;

    localparam logic [PWM_WIDTH-1:0]         SLOT_LAST  = PWM_WIDTH'((2 ** PWM_WIDTH) - 2);
    localparam logic [CLOCK_DELAY_WIDTH-1:0] CLK_LAST   = CLOCK_DELAY_WIDTH'(CLOCK_DELAY - 1);
    localparam logic [BLANK_WIDTH-1:0]       BLANK_LAST =
        BLANK_WIDTH'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [NUM_ROWS_WIDTH-1:0]    ROW_LAST   = NUM_ROWS_WIDTH'(NUM_ROWS - 1);
    localparam logic [NUM_ROWS-1:0]          ROWS_OFF   = (ROW_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_COLS-1:0]          COLS_OFF   = (COL_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SCAN
    } state_t;

    localparam state_t ROW_ENTRY = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SCAN;

    state_t                         r_state;
    logic [NUM_ROWS_WIDTH-1:0]      r_row;
    logic [BLANK_WIDTH-1:0]         r_blank_cnt;
    logic [PWM_WIDTH-1:0]           r_slot;
    logic [CLOCK_DELAY_WIDTH-1:0]   r_clk_cnt;
    logic [IMG_W-1:0]               r_shadow;
    logic [NUM_ROWS-1:0]            r_rows;
    logic [NUM_COLS-1:0]            r_cols;
    logic                           r_frame_start;

    state_t                         w_state_nxt;
    logic [NUM_ROWS_WIDTH-1:0]      w_row_nxt;
    logic [BLANK_WIDTH-1:0]         w_blank_nxt;
    logic [PWM_WIDTH-1:0]           w_slot_nxt;
    logic [CLOCK_DELAY_WIDTH-1:0]   w_clk_nxt;
    logic [IMG_W-1:0]               w_shadow_nxt;
    logic                           w_capture;
    logic                           w_row_start;
    logic [NUM_ROWS-1:0]            w_rows_on;
    logic [NUM_COLS-1:0]            w_cols_on;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_blank_nxt = r_blank_cnt;
        w_slot_nxt  = r_slot;
        w_clk_nxt   = r_clk_cnt;
        w_capture   = 1'b0;
        w_row_start = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_row_nxt   = '0;
                w_capture   = 1'b1;
                w_row_start = 1'b1;
            end
            ST_BLANK: begin
                if (r_blank_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_SCAN;
                    w_slot_nxt  = '0;
                    w_clk_nxt   = '0;
                end else begin
                    w_blank_nxt = r_blank_cnt + 1'b1;
                end
            end
            ST_SCAN: begin
                if (r_clk_cnt == CLK_LAST) begin
                    w_clk_nxt = '0;
                    if (r_slot == SLOT_LAST) begin
                        w_row_start = 1'b1;
                        if (r_row == ROW_LAST) begin
                            w_row_nxt = '0;
                            w_capture = 1'b1;
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                        end
                    end else begin
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_row_start) begin
            w_state_nxt = ROW_ENTRY;
            w_blank_nxt = '0;
            w_slot_nxt  = '0;
            w_clk_nxt   = '0;
        end

        // Dropping enable parks in IDLE with every counter and the image frozen.
        if (!i_enable) begin
            w_state_nxt = ST_IDLE;
            w_row_nxt   = r_row;
            w_blank_nxt = r_blank_cnt;
            w_slot_nxt  = r_slot;
            w_clk_nxt   = r_clk_cnt;
            w_capture   = 1'b0;
        end
    end

    assign w_shadow_nxt = w_capture ? i_pixels : r_shadow;

    // Outputs are derived from next-state values so each slot's compare lands on its first cycle.
    always_comb begin
        w_rows_on = '0;
        w_cols_on = '0;
        if (w_state_nxt == ST_SCAN) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                w_rows_on[r] = (w_row_nxt == NUM_ROWS_WIDTH'(r));
            end
            for (int c = 0; c < NUM_COLS; c++) begin
                w_cols_on[c] =
                    w_shadow_nxt[(int'(w_row_nxt) * NUM_COLS + c) * PWM_WIDTH +: PWM_WIDTH] > w_slot_nxt;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_row         <= '0;
            r_blank_cnt   <= '0;
            r_slot        <= '0;
            r_clk_cnt     <= '0;
            r_shadow      <= '0;
            r_rows        <= ROWS_OFF;
            r_cols        <= COLS_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_row         <= w_row_nxt;
            r_blank_cnt   <= w_blank_nxt;
            r_slot        <= w_slot_nxt;
            r_clk_cnt     <= w_clk_nxt;
            r_shadow      <= w_shadow_nxt;
            r_rows        <= w_rows_on ^ ROWS_OFF;
            r_cols        <= w_cols_on ^ COLS_OFF;
            r_frame_start <= w_capture;
        end
    end

    assign o_rows        = r_rows;
    assign o_cols        = r_cols;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_led_mux_pwm.sv
// Directed bench for led_mux_pwm: an active-high and an active-low instance share
// stimulus; every row is checked cycle by cycle against the pixel image the bench expects.
module tb_led_mux_pwm;

    localparam int IMG_W = 4 * 8 * 3;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             i_enable;
    logic [IMG_W-1:0] i_pixels;
    logic [7:0]       o_cols,  o_cols_n;
    logic [3:0]       o_rows,  o_rows_n;
    logic             o_frame_start, o_frame_start_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fs_cyc   = 0;

    logic [IMG_W-1:0] img_a, img_b, img_c, img_zero;
    int fs_frame2;

    always #5 clk = ~clk;

    led_mux_pwm u_dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_pixels      (i_pixels),
        .o_cols        (o_cols),
        .o_rows        (o_rows),
        .o_frame_start (o_frame_start)
    );

    led_mux_pwm #(
        .ROW_ACTIVE_LOW (1),
        .COL_ACTIVE_LOW (1)
    ) u_dut_n (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_pixels      (i_pixels),
        .o_cols        (o_cols_n),
        .o_rows        (o_rows_n),
        .o_frame_start (o_frame_start_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; inputs change here too.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [IMG_W-1:0] put(input logic [IMG_W-1:0] img, input int r,
                                             input int c, input logic [2:0] v);
        img[(r * 8 + c) * 3 +: 3] = v;
        return img;
    endfunction

    function automatic int pix(input logic [IMG_W-1:0] img, input int r, input int c);
        return int'(img[(r * 8 + c) * 3 +: 3]);
    endfunction

    // Called on the first blank cycle of a row; walks the 72-cycle row period and
    // leaves the bench on the first blank cycle of the following row.
    task automatic run_row(input int row, input logic [IMG_W-1:0] img,
                           input int chg_k, input logic [IMG_W-1:0] chg_val);
        int blank_bad = 0, fs_bad = 0, row_bad = 0, inv_bad = 0;
        int on_cnt[8];
        int shape_bad[8];
        logic [3:0] exp_rows;
        logic [7:0] exp_cols;
        for (int c = 0; c < 8; c++) begin
            on_cnt[c]    = 0;
            shape_bad[c] = 0;
        end
        for (int k = 0; k < 72; k++) begin
            if (k == chg_k) i_pixels = chg_val;
            if (o_frame_start !== ((row == 0 && k == 0) ? 1'b1 : 1'b0)) fs_bad++;
            if (row == 0 && k == 0) fs_cyc = cyc;
            if (k < 2) begin
                exp_rows = 4'b0000;
                exp_cols = 8'h00;
                if (o_rows !== 4'b0000 || o_cols !== 8'h00) blank_bad++;
            end else begin
                exp_rows = 4'b0001 << row;
                for (int c = 0; c < 8; c++) begin
                    exp_cols[c] = (pix(img, row, c) > (k - 2) / 10);
                    if (o_cols[c] === 1'b1) on_cnt[c]++;
                    if (o_cols[c] !== exp_cols[c]) shape_bad[c]++;
                end
                if (o_rows !== exp_rows) row_bad++;
            end
            if (o_rows_n !== ~exp_rows || o_cols_n !== ~exp_cols) inv_bad++;
            step();
        end
        check($sformatf("r%0d_blank", row), blank_bad, 0);
        check($sformatf("r%0d_fstart", row), fs_bad, 0);
        check($sformatf("r%0d_row_on", row), row_bad, 0);
        check($sformatf("r%0d_active_low", row), inv_bad, 0);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("r%0d_c%0d_on_clocks", row, c), on_cnt[c], 10 * pix(img, row, c));
            check($sformatf("r%0d_c%0d_shape", row, c), shape_bad[c], 0);
        end
    endtask

    initial begin
        img_zero = '0;
        img_a    = '0;
        img_a    = put(img_a, 0, 1, 3'd1);
        img_a    = put(img_a, 0, 3, 3'd4);
        img_a    = put(img_a, 0, 7, 3'd7);
        img_b    = '1;
        img_c    = '0;
        for (int c = 0; c < 8; c++) begin
            img_a = put(img_a, 1, c, 3'd2);
            img_a = put(img_a, 2, c, 3'(c));
            img_c = put(img_c, 0, c, 3'd5);
            img_c = put(img_c, 1, c, 3'(7 - c));
            img_c = put(img_c, 2, c, 3'd3);
            img_c = put(img_c, 3, c, 3'd3);
        end

        i_rst    = 1'b1;
        i_enable = 1'b0;
        i_pixels = '0;
        step();
        step();
        check("rst_rows", o_rows, 4'b0000);
        check("rst_cols", o_cols, 8'h00);
        check("rst_fstart", o_frame_start, 1'b0);
        check("rst_rows_n", o_rows_n, 4'b1111);
        check("rst_cols_n", o_cols_n, 8'hFF);

        // Frame 1: mixed intensities; all-7 applied early must not leak into this frame.
        i_pixels = img_a;
        i_rst    = 1'b0;
        i_enable = 1'b1;
        step();
        run_row(0, img_a, -1, img_zero);
        i_pixels = img_b;
        run_row(1, img_a, -1, img_zero);
        run_row(2, img_a, -1, img_zero);
        run_row(3, img_a, -1, img_zero);

        // Frame 2: full duty; the image drops to 0 during row-1 SCAN without tearing.
        run_row(0, img_b, -1, img_zero);
        fs_frame2 = fs_cyc;
        run_row(1, img_b, 30, img_zero);
        run_row(2, img_b, -1, img_zero);
        run_row(3, img_b, -1, img_zero);

        // Frame 3: dark image, then enable drops in the middle of row 2.
        run_row(0, img_zero, -1, img_zero);
        check("frame_period", fs_cyc - fs_frame2, 288);
        run_row(1, img_zero, -1, img_zero);
        repeat (21) step();
        check("en_pre_rows", o_rows, 4'b0100);
        i_enable = 1'b0;
        i_pixels = img_c;
        step();
        check("en_off_rows", o_rows, 4'b0000);
        check("en_off_cols", o_cols, 8'h00);
        check("en_off_rows_n", o_rows_n, 4'b1111);
        repeat (3) step();
        check("en_idle_rows", o_rows, 4'b0000);
        check("en_idle_fstart", o_frame_start, 1'b0);
        i_enable = 1'b1;
        step();
        run_row(0, img_c, -1, img_zero);
        run_row(1, img_c, -1, img_zero);

        // Reset held for three clocks in the middle of row 2.
        repeat (30) step();
        check("rst_pre_rows", o_rows, 4'b0100);
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst%0d_rows", i), o_rows, 4'b0000);
            check($sformatf("rst%0d_cols", i), o_cols, 8'h00);
            check($sformatf("rst%0d_fstart", i), o_frame_start, 1'b0);
        end
        i_rst = 1'b0;
        step();
        run_row(0, img_c, -1, img_zero);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
